lsu_controller: RTL
===================

LSU_CONTROLLER -- requirements
Module: lsu_controller

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the maximum number of REQ-state cycles waited for busAck (1..255).
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 memRead  in  1  current instruction is a load (resultSource==01).
REQ-005 memWrite  in  1  current instruction is a store.
REQ-006 funct3  in  3  load/store width and signedness from the instruction.
REQ-007 address  in  32  ALU-computed effective byte address.
REQ-008 storeData  in  32  rs2 value for stores.
REQ-009 stall  out  1  holds PC and the instruction while high.
REQ-010 loadData  out  32  extended load result, registered.
REQ-011 loadValid  out  1  one-cycle pulse; loadData valid.
REQ-012 misalign  out  1  one-cycle pulse; misaligned or illegal-funct3 access dropped.
REQ-013 busFault  out  1  one-cycle pulse; bus timeout.
REQ-014 busReq, busWe  out  1 each  request, write-enable.
REQ-015 busAddr  out  32  word address; address with bits[1:0] forced to 00.
REQ-016 busByteEn  out  4  byte-lane enables.
REQ-017 busWData  out  32  lane-replicated store data.
REQ-018 busRData  in  32  read data, valid when busAck=1.
REQ-019 busAck  in  1  transfer complete.

Function
REQ-020 FSM states SHALL be IDLE, REQ, DONE, ERR.
REQ-021 IDLE: on (memRead|memWrite) with a legal, aligned access -> REQ; busAddr/busByteEn/busWData/busWe are registered at that edge.
REQ-022 memWrite SHALL take priority when memRead and memWrite are both high; the access is treated as a store.
REQ-023 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW; any other funct3 is illegal.
REQ-024 Alignment: halfword requires address[0]=0; word requires address[1:0]=00; byte is always aligned.
REQ-025 Illegal or misaligned access in IDLE: no bus request, misalign=1 for that cycle (combinational), stall=0, state stays IDLE.
REQ-026 stall = (IDLE & (memRead|memWrite) & legal & aligned) | REQ; stall=0 in DONE and ERR.
REQ-027 REQ: busReq=1; busAddr, busByteEn, busWData, and busWe stay stable until busAck is sampled high.
REQ-028 REQ with busAck=1 -> DONE; for a load, loadData is captured from busRData at that edge.
REQ-029 Byte lanes: SB/LB(U) 0001<<address[1:0]; SH/LH(U) 0011<<address[1:0]; SW/LW 1111.
REQ-030 busWData: SB replicates byte[7:0] x4; SH replicates half[15:0] x2; SW passes through.
REQ-031 Load extract: select the addressed byte/half by address[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-032 DONE: loadValid=1 for loads only; busReq=0; next state is IDLE unconditionally.
REQ-033 An 8-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without busAck; when it reaches TIMEOUT -> ERR.
REQ-034 ERR: busFault=1, busReq=0, loadData unchanged, next state is IDLE.
REQ-035 busAck in IDLE, DONE, or ERR SHALL be ignored.
REQ-036 Minimum load/store latency: issue cycle plus REQ (ack on first REQ cycle) plus DONE, i.e. stall high for 2 cycles.

Reset
REQ-037 When rst=1 at a clock edge: state=IDLE, counter=0, loadData=0, busAddr=0, busByteEn=0, busWData=0, busWe=0; busReq, stall (registered terms), loadValid, misalign, and busFault are all 0.
REQ-038 Reset during REQ SHALL abandon the transfer; busReq is 0 from the next cycle and a late busAck is ignored.

Verification
REQ-039 LW at 0x100, busRData=0xDEADBEEF, ack on first REQ cycle -> busByteEn=1111, stall high 2 cycles, loadValid with loadData=0xDEADBEEF.
REQ-040 LB at 0x103, busRData=0x80xxxxxx -> busByteEn=1000, loadData=0xFFFFFF80; LBU at the same address -> loadData=0x00000080.
REQ-041 SH at 0x202, storeData=0x1234ABCD -> busAddr=0x200, busByteEn=1100, busWData=0xABCDABCD, busWe=1, loadValid stays 0.
REQ-042 LW at 0x101 -> misalign pulse, busReq never asserted, stall=0; funct3=011 load -> same result.
REQ-043 TIMEOUT=4 with no ack -> busReq high 4 cycles, then busFault pulse, then IDLE.
REQ-044 rst during REQ with ack 1 cycle later -> no loadValid, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/lsu_controller.sv
// Load/store unit: turns one load or store into a single-beat bus transfer,
// stalling the core until the bus acknowledges or the wait times out.
module lsu_controller #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        misalign,
  output logic        busFault,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [3:0]  busByteEn,
  output logic [31:0] busWData,
  input  logic [31:0] busRData,
  input  logic        busAck
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_isLoad;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addrLo;
  logic [31:0] r_loadData;
  logic [31:0] r_busAddr;
  logic [3:0]  r_busByteEn;
  logic [31:0] r_busWData;
  logic        r_busWe;

  logic        w_access;
  logic        w_legal;
  logic        w_aligned;
  logic        w_issue;
  logic [3:0]  w_byteEn;
  logic [31:0] w_wdata;
  logic [7:0]  w_cntInc;
  logic        w_timeout;

  // Picks the addressed byte/half out of the read word and extends it.
  function automatic logic [31:0] extract_load(input logic [31:0] data,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lo);
    logic [31:0]        shifted;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    shifted = data >> {lo, 3'b000};
    sb      = shifted[7:0];
    sh      = shifted[15:0];
    case (f3)
      3'b000:  extract_load = 32'(sb);
      3'b001:  extract_load = 32'(sh);
      3'b100:  extract_load = {24'b0, shifted[7:0]};
      3'b101:  extract_load = {16'b0, shifted[15:0]};
      default: extract_load = data;
    endcase
  endfunction

  always_comb begin
    w_access  = memRead | memWrite;
    w_legal   = 1'b0;
    w_aligned = 1'b0;
    // A store wins when both strobes are high, so store legality applies.
    if (memWrite)
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    case (funct3[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~address[0];
      2'b10:   w_aligned = (address[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
    w_issue = w_access & w_legal & w_aligned;
    case (funct3[1:0])
      2'b00:   w_byteEn = 4'b0001 << address[1:0];
      2'b01:   w_byteEn = 4'b0011 << address[1:0];
      default: w_byteEn = 4'b1111;
    endcase
    case (funct3[1:0])
      2'b00:   w_wdata = {4{storeData[7:0]}};
      2'b01:   w_wdata = {2{storeData[15:0]}};
      default: w_wdata = storeData;
    endcase
    w_cntInc  = r_cnt + 8'd1;
    w_timeout = (w_cntInc == 8'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_issue) w_next = S_REQ;
      S_REQ: begin
        if (busAck)         w_next = S_DONE;
        else if (w_timeout) w_next = S_ERR;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busReq    = (r_state == S_REQ);
    stall     = ((r_state == S_IDLE) & w_issue) | (r_state == S_REQ);
    loadValid = (r_state == S_DONE) & r_isLoad;
    misalign  = (r_state == S_IDLE) & w_access & ~(w_legal & w_aligned);
    busFault  = (r_state == S_ERR);
  end

  // Issue edge: latch the bus request; ack edge: capture the load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 8'd0;
      r_isLoad    <= 1'b0;
      r_funct3    <= 3'b000;
      r_addrLo    <= 2'b00;
      r_loadData  <= 32'd0;
      r_busAddr   <= 32'd0;
      r_busByteEn <= 4'd0;
      r_busWData  <= 32'd0;
      r_busWe     <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_issue) begin
        r_cnt       <= 8'd0;
        r_isLoad    <= ~memWrite;
        r_funct3    <= funct3;
        r_addrLo    <= address[1:0];
        r_busAddr   <= {address[31:2], 2'b00};
        r_busByteEn <= w_byteEn;
        r_busWData  <= w_wdata;
        r_busWe     <= memWrite;
      end else if (r_state == S_REQ && !busAck) begin
        r_cnt <= w_cntInc;
      end
      if (r_state == S_REQ && busAck && r_isLoad)
        r_loadData <= extract_load(busRData, r_funct3, r_addrLo);
    end
  end

  assign loadData  = r_loadData;
  assign busAddr   = r_busAddr;
  assign busByteEn = r_busByteEn;
  assign busWData  = r_busWData;
  assign busWe     = r_busWe;

endmodule
